// File: rtl/oddr_gearbox_pkg.sv
// rtl/oddr_gearbox_pkg.sv - shared helpers for the DDR output gearbox
//
// Purpose: beat-count derivation, RATIO legality check and the beat-to-bit
// mapping shared by the gearbox top and its per-lane muxes.
// Ports: none (package).

package oddr_gearbox_pkg;

  // One DDR beat carries two bits per lane, so a word of RATIO bits per lane
  // takes RATIO/2 clock cycles.
  function automatic int beats_of(input int ratio);
    return ratio / 2;
  endfunction

  function automatic bit ratio_ok(input int ratio);
    return (ratio >= 2) && ((ratio % 2) == 0);
  endfunction

  // Bit index inside one lane's RATIO-bit slice for beat k.
  // second=0 selects the rising-edge (d1) bit, second=1 the falling-edge (d2) bit.
  function automatic int beat_bit(input int k, input int ratio, input bit msb_first,
                                  input bit second);
    int idx;
    idx = 2 * k + (second ? 1 : 0);
    return msb_first ? (ratio - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/oddr_gearbox_lane.sv
// rtl/oddr_gearbox_lane.sv - per-lane beat mux for the DDR output gearbox
//
// Purpose: pick the rising/falling-edge bit pair of one lane for a given beat.
// Ports:
//   lane_data_i  RATIO-bit slice of the word belonging to this lane
//   beat_i       beat number 0..BEATS-1
//   d1_o / d2_o  rising-edge / falling-edge bit for that beat

module oddr_gearbox_lane
  import oddr_gearbox_pkg::*;
#(
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CW        = 1
) (
  input  logic [RATIO-1:0] lane_data_i,
  input  logic [CW-1:0]    beat_i,
  output logic             d1_o,
  output logic             d2_o
);

  localparam int BEATS = beats_of(RATIO);

  // Unrolled one-hot compare keeps every index constant; beat codes beyond
  // BEATS-1 (possible when BEATS is not a power of two) fall through to 0.
  always_comb begin
    d1_o = 1'b0;
    d2_o = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_i == CW'(k)) begin
        d1_o = lane_data_i[beat_bit(k, RATIO, MSB_FIRST, 1'b0)];
        d2_o = lane_data_i[beat_bit(k, RATIO, MSB_FIRST, 1'b1)];
      end
    end
  end

endmodule

// File: rtl/oddr_gearbox.sv
// rtl/oddr_gearbox.sv - multi-lane serializer feeding DDR output cells
//
// Purpose: accept WIDTH*RATIO-bit words over valid/ready, emit RATIO/2 beats
// per word as registered rising/falling bit pairs per lane, with idle fill,
// framing flags and underflow reporting.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   s_data/s_valid   input word and its valid; lane i at [i*RATIO +: RATIO]
//   s_ready          word accepted on an edge with s_valid && s_ready
//   q_d1/q_d2        registered rising/falling-edge bit per lane
//   q_active         q_d1/q_d2 carry word data
//   q_first          beat 0 of a word
//   underflow        one-cycle pulse when a word ends with nothing buffered

module oddr_gearbox
  import oddr_gearbox_pkg::*;
#(
  parameter int   WIDTH      = 1,
  parameter int   RATIO      = 4,
  parameter bit   MSB_FIRST  = 1'b0,
  parameter logic IDLE_VALUE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH*RATIO-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [WIDTH-1:0]       q_d1,
  output logic [WIDTH-1:0]       q_d2,
  output logic                   q_active,
  output logic                   q_first,
  output logic                   underflow
);

  localparam int             W         = WIDTH * RATIO;
  localparam int             BEATS     = beats_of(RATIO);
  localparam int             CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]  LAST_BEAT = CW'(BEATS - 1);

  if (!ratio_ok(RATIO)) begin : g_bad_ratio
    $error("oddr_gearbox: RATIO must be even and >= 2");
  end

  logic             hold_valid_q, hold_valid_d;
  logic [W-1:0]     hold_data_q, hold_data_d;
  logic [W-1:0]     shift_data_q, shift_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [WIDTH-1:0] q_d1_q, q_d1_d, q_d2_q, q_d2_d;
  logic             q_active_q, q_active_d;
  logic             q_first_q, q_first_d;
  logic             underflow_q, underflow_d;

  logic             slot_free, load, accept, advance;
  logic [W-1:0]     mux_data;
  logic [CW-1:0]    mux_beat;
  logic [WIDTH-1:0] beat_d1, beat_d2;

  // The shifter can take a new word when idle or on its last beat, which is
  // what allows back-to-back words with no gap.
  assign slot_free = !active_q || (cnt_q == LAST_BEAT);
  assign load      = hold_valid_q && slot_free;
  assign s_ready   = !hold_valid_q || load;
  assign accept    = s_valid && s_ready;
  assign advance   = active_q && (cnt_q != LAST_BEAT);

  // A load presents beat 0 of the hold word; otherwise the next beat of the
  // word already in the shifter. The lane muxes serve both cases.
  assign mux_data = load ? hold_data_q : shift_data_q;
  assign mux_beat = load ? '0 : cnt_q + CW'(1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    oddr_gearbox_lane #(
      .RATIO     (RATIO),
      .MSB_FIRST (MSB_FIRST),
      .CW        (CW)
    ) u_lane (
      .lane_data_i (mux_data[i*RATIO +: RATIO]),
      .beat_i      (mux_beat),
      .d1_o        (beat_d1[i]),
      .d2_o        (beat_d2[i])
    );
  end

  always_comb begin
    hold_valid_d = (hold_valid_q && !load) || accept;
    hold_data_d  = accept ? s_data : hold_data_q;
    shift_data_d = shift_data_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    q_d1_d       = {WIDTH{IDLE_VALUE}};
    q_d2_d       = {WIDTH{IDLE_VALUE}};
    q_active_d   = 1'b0;
    q_first_d    = 1'b0;
    underflow_d  = 1'b0;
    if (load) begin
      shift_data_d = hold_data_q;
      cnt_d        = '0;
      active_d     = 1'b1;
      q_d1_d       = beat_d1;
      q_d2_d       = beat_d2;
      q_active_d   = 1'b1;
      q_first_d    = 1'b1;
    end else if (advance) begin
      cnt_d      = cnt_q + CW'(1);
      q_d1_d     = beat_d1;
      q_d2_d     = beat_d2;
      q_active_d = 1'b1;
    end else begin
      // Idle, or a word just finished with nothing waiting behind it.
      active_d    = 1'b0;
      cnt_d       = '0;
      underflow_d = active_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      cnt_q        <= '0;
      active_q     <= 1'b0;
      q_d1_q       <= {WIDTH{IDLE_VALUE}};
      q_d2_q       <= {WIDTH{IDLE_VALUE}};
      q_active_q   <= 1'b0;
      q_first_q    <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      q_d1_q       <= q_d1_d;
      q_d2_q       <= q_d2_d;
      q_active_q   <= q_active_d;
      q_first_q    <= q_first_d;
      underflow_q  <= underflow_d;
    end
  end

  // Data registers carry no reset; the valid/active flags qualify them.
  always_ff @(posedge clk) begin
    hold_data_q  <= hold_data_d;
    shift_data_q <= shift_data_d;
  end

  assign q_d1      = q_d1_q;
  assign q_d2      = q_d2_q;
  assign q_active  = q_active_q;
  assign q_first   = q_first_q;
  assign underflow = underflow_q;

endmodule
